// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment patterns are active low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [3:0] digit_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to active-low segment lookup.
// Used once on the already-muxed digit.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  digit_t     digit,
  output logic [6:0] seg
);

  // Plain lookup, every code covered
  always_comb begin
    seg = SEG_BLANK;
    unique case (digit)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit refresh scanner with double-buffered display data.
// seg is registered from next-state en/display so both move together.
module seven_seg_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic        lz_en,
  output logic [1:0]  en,
  output logic [6:0]  seg,
  output logic        load_pending,
  output logic        frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] prescaler;
  logic [15:0]      shadow;
  logic [15:0]      display;

  logic        tick;
  logic        commit;
  logic [1:0]  en_nxt;
  logic [15:0] disp_nxt;
  digit_t      cur;
  logic        blank;
  logic [6:0]  pat;

  // Slot timing and the display value after this edge
  always_comb begin
    tick     = (prescaler == LAST);
    commit   = tick && (en == 2'd3);
    en_nxt   = tick ? en + 2'd1 : en;
    disp_nxt = display;
    if (commit && load)
      disp_nxt = digits_in;
    else if (commit && load_pending)
      disp_nxt = shadow;
  end

  // Digit mux and leading-zero blanking on the upcoming slot
  always_comb begin
    cur   = disp_nxt[4*en_nxt +: 4];
    blank = 1'b0;
    unique case (en_nxt)
      2'd3: blank = lz_en && (disp_nxt[15:12] == 4'h0);
      2'd2: blank = lz_en && (disp_nxt[15:8] == 8'h00);
      2'd1: blank = lz_en && (disp_nxt[15:4] == 12'h000);
      2'd0: blank = 1'b0;
    endcase
  end

  hex_to_seg7 u_dec (
    .digit (cur),
    .seg   (pat)
  );

  // Prescaler, digit select, double buffer and output register
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler    <= '0;
      en           <= 2'd0;
      shadow       <= 16'h0000;
      display      <= 16'h0000;
      load_pending <= 1'b0;
      frame_done   <= 1'b0;
      seg          <= SEG_0;
    end else begin
      prescaler  <= tick ? '0 : prescaler + 1'b1;
      en         <= en_nxt;
      display    <= disp_nxt;
      frame_done <= commit;
      if (load) begin
        shadow       <= digits_in;
        load_pending <= !commit;
      end else if (commit) begin
        load_pending <= 1'b0;
      end
      if (tick)
        seg <= blank ? SEG_BLANK : pat;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl with REFRESH_DIV=4.
// Reference model works from a cycle count since reset.
module tb_seven_seg_scan_ctrl;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0;
  logic        lz_en = 1'b0;
  logic [1:0]  en;
  logic [6:0]  seg;
  logic        load_pending;
  logic        frame_done;

  seven_seg_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .digits_in    (digits_in),
    .lz_en        (lz_en),
    .en           (en),
    .seg          (seg),
    .load_pending (load_pending),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int unsigned c;
  logic [15:0] m_disp, m_shd;
  logic        m_pend, m_fd;
  logic [6:0]  m_seg;
  logic [1:0]  m_en;
  int tests = 0;
  int fails = 0;

  function automatic logic [6:0] pattern(logic [15:0] d, int slot, bit lz);
    logic [15:0] upper;
    logic [3:0]  dg;
    upper = d >> (4 * slot);
    dg = upper[3:0];
    if (lz && slot > 0 && upper == 16'h0)
      return 7'h7F;
    return hex_tab[dg];
  endfunction

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %h exp %h (c=%0d)", tag, got, exp, c);
    end
  endtask

  task automatic cyc(bit r, bit ld, logic [15:0] d, bit lz);
    bit tick, commit;
    @(negedge clk);
    reset = r; load = ld; digits_in = d; lz_en = lz;
    @(posedge clk);
    if (r) begin
      c = 0; m_disp = 0; m_shd = 0; m_pend = 0; m_fd = 0;
      m_seg = hex_tab[0];
    end else begin
      tick = (c % DIV) == DIV - 1;
      commit = tick && ((c / DIV) % 4) == 3;
      if (ld && commit) begin
        m_disp = d; m_shd = d; m_pend = 0;
      end else if (ld) begin
        m_shd = d; m_pend = 1;
      end else if (commit) begin
        if (m_pend) m_disp = m_shd;
        m_pend = 0;
      end
      m_fd = commit;
      c++;
      if (tick) m_seg = pattern(m_disp, (c / DIV) % 4, lz);
    end
    m_en = 2'((c / DIV) % 4);
    #1;
    chk("en", 16'(en), 16'(m_en));
    chk("seg", 16'(seg), 16'(m_seg));
    chk("load_pending", 16'(load_pending), 16'(m_pend));
    chk("frame_done", 16'(frame_done), 16'(m_fd));
  endtask

  task automatic idle_until(int unsigned ph, bit lz);
    int n = 0;
    while ((c % (4 * DIV)) != ph && n < 64) begin
      cyc(0, 0, 16'h0, lz);
      n++;
    end
    chk("phase_reach", 16'(c % (4 * DIV)), 16'(ph));
  endtask

  initial begin
    bit lz;
    int fd_cnt;
    cyc(1, 0, 16'h0, 0);
    cyc(1, 0, 16'h0, 0);
    chk("rst_en", 16'(en), 16'd0);
    chk("rst_seg", 16'(seg), 16'b1000000);
    chk("rst_pend", 16'(load_pending), 16'd0);

    fd_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cyc(0, 0, 16'h0, 0);
      if (frame_done) fd_cnt++;
    end
    chk("fd_per_32", 16'(fd_cnt), 16'd2);

    idle_until(5, 0);
    cyc(0, 1, 16'h1234, 0);
    chk("pend_1234", 16'(load_pending), 16'd1);
    idle_until(0, 0);
    chk("show_4", 16'(seg), 16'b0011001);

    idle_until(2, 1);
    cyc(0, 1, 16'hAAAA, 1);
    cyc(0, 1, 16'h00F7, 1);
    idle_until(0, 1);
    chk("show_7", 16'(seg), 16'b1111000);
    idle_until(4 + 0, 1);
    chk("show_F", 16'(seg), 16'b0001110);
    idle_until(8, 1);
    chk("blank2", 16'(seg), 16'h7F);

    idle_until(15, 1);
    cyc(0, 1, 16'h0000, 1);
    chk("commit_load_pend", 16'(load_pending), 16'd0);
    chk("commit_load_seg", 16'(seg), 16'b1000000);
    idle_until(12, 1);
    chk("zero_blank3", 16'(seg), 16'h7F);

    idle_until(9, 0);
    cyc(0, 1, 16'h9999, 0);
    cyc(1, 0, 16'h0, 0);
    chk("rst_mid_pend", 16'(load_pending), 16'd0);
    chk("rst_mid_seg", 16'(seg), 16'b1000000);

    cyc(0, 1, 16'h0500, 0);
    idle_until(13, 0);
    chk("lz_off_d3", 16'(seg), 16'b1000000);
    cyc(0, 0, 16'h0, 1);
    chk("lz_late", 16'(seg), 16'b1000000);
    idle_until(0, 1);
    chk("lz_d0", 16'(seg), 16'b1000000);
    idle_until(12, 1);
    chk("lz_d3", 16'(seg), 16'h7F);

    lz = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) lz = ~lz;
      cyc($urandom_range(0, 149) == 0,
          $urandom_range(0, 9) == 0,
          16'($urandom), lz);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
